store_align_unit: RTL and testbench

//  Parametrised store-side alignment unit between the MEM stage and the data-memory port.

---
 rtl/store_align_unit.sv | 165 ++++++++++++++++
 tb/tb_store_align_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/store_align_unit.sv
// store_align_unit
//   Store-side alignment between the MEM stage and the data-memory port.
//   Takes one store (byte address, funct3, LSB-justified rs2 data) per
//   handshake. It turns the store into a word-aligned address, lane-aligned
//   write data and a byte-enable mask, then drives the memory write handshake.
//
//   Build option STORE_MISALIGN_SPLIT_EN:
//     defined   - a store that crosses a word boundary is written as two
//                 back-to-back word writes, with one idle cycle between them.
//     undefined - any store with off % size != 0 is rejected with err.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       store request handshake (ready == unit idle)
//   req_addr/funct3/wdata     byte address, sb/sh/sw/sd, raw store data
//   mem_write                 write strobe, held until mem_resp
//   mem_address               word-aligned address
//   mem_wdata/byte_enable     lane-aligned data and per-byte mask
//   mem_resp                  memory finished the current write
//   done                      1-cycle pulse: store fully committed
//   err                       1-cycle pulse: store rejected, nothing written
module store_align_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [2:0]              req_funct3,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    mem_write,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  input  logic                    mem_resp,
  output logic                    done,
  output logic                    err
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFW  = $clog2(BYTES);

`ifdef STORE_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  // S_GAP is the mandatory idle cycle between the two beats of a split store.
  typedef enum logic [2:0] {S_IDLE, S_BEAT0, S_GAP, S_BEAT1, S_DONE} state_t;

  state_t                r_state;
  logic                  r_ready, r_write, r_done, r_err, r_split;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_hi_wdata;
  logic [BYTES-1:0]      r_be, r_hi_be;

  logic [OFFW-1:0]         w_off;
  int                      w_sz;
  logic [DATA_WIDTH-1:0]   w_dsel;
  logic [2*BYTES-1:0]      w_szmask, w_mask;
  logic [2*DATA_WIDTH-1:0] w_data;
  logic                    w_illegal;

  assign w_off = req_addr[OFFW-1:0];

  // Two-word-wide mask and data. The low half goes to beat 0 and the high
  // half to beat 1. A non-zero high mask means the store crosses a word.
  always_comb begin
    case (req_funct3[1:0])
      2'd0:    w_sz = 1;
      2'd1:    w_sz = 2;
      2'd2:    w_sz = 4;
      default: w_sz = 8;
    endcase
    w_szmask = '0;
    w_dsel   = '0;
    for (int i = 0; i < 2*BYTES; i++) w_szmask[i] = (i < w_sz);
    for (int b = 0; b < BYTES; b++)
      if (b < w_sz) w_dsel[b*8 +: 8] = req_wdata[b*8 +: 8];
    w_mask    = w_szmask << w_off;
    w_data    = {{DATA_WIDTH{1'b0}}, w_dsel} << {w_off, 3'b000};
    w_illegal = req_funct3[2] | (w_sz > BYTES);
    if (!SPLIT_EN && ((int'(w_off) % w_sz) != 0)) w_illegal = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b1;
      r_write    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_split    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_hi_wdata <= '0;
      r_hi_be    <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (w_illegal) begin
              r_err <= 1'b1;
            end else begin
              r_state    <= S_BEAT0;
              r_ready    <= 1'b0;
              r_write    <= 1'b1;
              r_addr     <= {req_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
              r_wdata    <= w_data[DATA_WIDTH-1:0];
              r_be       <= w_mask[BYTES-1:0];
              r_hi_wdata <= w_data[2*DATA_WIDTH-1:DATA_WIDTH];
              r_hi_be    <= w_mask[2*BYTES-1:BYTES];
              r_split    <= |w_mask[2*BYTES-1:BYTES];
            end
          end
        end
        S_BEAT0: begin
          if (mem_resp) begin
            r_write <= 1'b0;
            if (SPLIT_EN && r_split) begin
              r_state <= S_GAP;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_GAP: begin
          // Second word; the address wraps naturally at 2^ADDR_WIDTH.
          r_state <= S_BEAT1;
          r_write <= 1'b1;
          r_addr  <= r_addr + ADDR_WIDTH'(BYTES);
          r_wdata <= r_hi_wdata;
          r_be    <= r_hi_be;
        end
        S_BEAT1: begin
          if (mem_resp) begin
            r_write <= 1'b0;
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready       = r_ready;
  assign mem_write       = r_write;
  assign mem_address     = r_addr;
  assign mem_wdata       = r_wdata;
  assign mem_byte_enable = r_be;
  assign done            = r_done;
  assign err             = r_err;

endmodule

// File: tb/tb_store_align_unit.sv
// Randomised bench for store_align_unit. It drives a 32-bit and a 64-bit
// instance. A byte-by-byte reference model predicts the beats of each store,
// and every observed output is checked against that prediction.
module tb_store_align_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid, mem_resp;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [63:0] req_wdata;

  logic        a_ready, a_write, a_done, a_err;
  logic [31:0] a_addr, a_wdata;
  logic [3:0]  a_be;
  logic        b_ready, b_write, b_done, b_err;
  logic [31:0] b_addr;
  logic [63:0] b_wdata;
  logic [7:0]  b_be;

  logic        o_ready, o_write, o_done, o_err;
  logic [31:0] o_addr;
  logic [63:0] o_wdata;
  logic [7:0]  o_be;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  store_align_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) u_w32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~sel), .req_ready(a_ready),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata[31:0]),
    .mem_write(a_write), .mem_address(a_addr), .mem_wdata(a_wdata),
    .mem_byte_enable(a_be), .mem_resp(mem_resp & ~sel),
    .done(a_done), .err(a_err));

  store_align_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) u_w64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & sel), .req_ready(b_ready),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .mem_write(b_write), .mem_address(b_addr), .mem_wdata(b_wdata),
    .mem_byte_enable(b_be), .mem_resp(mem_resp & sel),
    .done(b_done), .err(b_err));

  always_comb begin
    o_ready = sel ? b_ready : a_ready;
    o_write = sel ? b_write : a_write;
    o_done  = sel ? b_done  : a_done;
    o_err   = sel ? b_err   : a_err;
    o_addr  = sel ? b_addr  : a_addr;
    o_wdata = sel ? b_wdata : {32'h0, a_wdata};
    o_be    = sel ? b_be    : {4'h0, a_be};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One store on the selected instance. The memory answers after dly extra cycles.
  task automatic run_store(input logic s, input logic [31:0] a, input logic [2:0] f3,
                           input logic [63:0] d, input int dly);
    int          bw, sz, off, nb, p;
    bit          ill;
    logic [7:0]  em [2];
    logic [63:0] ed [2];
    logic [31:0] ea [2];
    bw  = s ? 8 : 4;
    sz  = 1 << f3[1:0];
    off = int'(a % 32'(bw));
    ill = f3[2] || (sz > bw);
`ifdef STORE_MISALIGN_SPLIT_EN
    nb = (off + sz > bw) ? 2 : 1;
`else
    if (off % sz != 0) ill = 1'b1;
    nb = 1;
`endif
    em[0] = '0; em[1] = '0; ed[0] = '0; ed[1] = '0;
    ea[0] = a - 32'(off);
    ea[1] = ea[0] + 32'(bw);
    if (!ill)
      for (int k = 0; k < sz; k++) begin
        p = off + k;
        em[p / bw][p % bw] = 1'b1;
        ed[p / bw][(p % bw)*8 +: 8] = d[k*8 +: 8];
      end

    sel = s;
    @(negedge clk);
    check("ready_before", 64'(o_ready), 64'd1);
    req_valid = 1'b1; req_addr = a; req_funct3 = f3; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (ill) begin
      check("err_pulse", 64'(o_err), 64'd1);
      check("err_nowrite", 64'(o_write), 64'd0);
      @(posedge clk); #1;
      check("err_clear", 64'(o_err), 64'd0);
      check("err_nowrite2", 64'(o_write), 64'd0);
      check("err_ready", 64'(o_ready), 64'd1);
      return;
    end
    check("busy_ready", 64'(o_ready), 64'd0);
    for (int b = 0; b < nb; b++) begin
      if (b == 1) begin
        check("gap_write", 64'(o_write), 64'd0);
        check("gap_done", 64'(o_done), 64'd0);
        @(posedge clk); #1;
      end
      for (int c = 0; c <= dly; c++) begin
        check("beat_write", 64'(o_write), 64'd1);
        check("beat_addr", 64'(o_addr), 64'(ea[b]));
        check("beat_wdata", o_wdata, ed[b]);
        check("beat_be", 64'(o_be), 64'(em[b]));
        check("beat_nodone", 64'(o_done), 64'd0);
        if (c < dly) begin @(posedge clk); #1; end
      end
      mem_resp = 1'b1;
      @(posedge clk); #1;
      mem_resp = 1'b0;
      check("resp_write_low", 64'(o_write), 64'd0);
    end
    check("done_pulse", 64'(o_done), 64'd1);
    @(posedge clk); #1;
    check("done_clear", 64'(o_done), 64'd0);
    check("idle_ready", 64'(o_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [2:0]  rf;
    sel = 1'b0; req_valid = 1'b0; mem_resp = 1'b0;
    req_addr = '0; req_funct3 = '0; req_wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_write", 64'(a_write | b_write), 64'd0);
    check("rst_done", 64'(a_done | b_done), 64'd0);
    check("rst_err", 64'(a_err | b_err), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", 64'({a_ready, b_ready}), 64'd3);

    run_store(1'b0, 32'h1003, 3'b000, 64'hAB, 0);
    run_store(1'b0, 32'h2002, 3'b001, 64'hBEEF, 1);
    run_store(1'b0, 32'h3003, 3'b010, 64'h11223344, 2);
    run_store(1'b0, 32'h1000, 3'b011, 64'h0123456789ABCDEF, 0);
    run_store(1'b1, 32'h4000, 3'b011, 64'h0123456789ABCDEF, 1);
    run_store(1'b0, 32'h5001, 3'b001, 64'hCAFE, 0);
    run_store(1'b0, 32'hFFFF_FFFE, 3'b010, 64'hA1B2C3D4, 0);
    run_store(1'b1, 32'hFFFF_FFFC, 3'b011, 64'h1122334455667788, 1);
    run_store(1'b0, 32'h6000, 3'b100, 64'h12345678, 0);

    // mem_resp while idle must not produce activity.
    sel = 1'b0;
    mem_resp = 1'b1;
    @(posedge clk); #1;
    mem_resp = 1'b0;
    check("idle_resp_write", 64'(o_write), 64'd0);
    check("idle_resp_done", 64'(o_done), 64'd0);

    // Reset while a write waits for mem_resp.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h7000; req_funct3 = 3'b010; req_wdata = 64'h55AA55AA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_write_up", 64'(o_write), 64'd1);
    @(negedge clk) rst = 1'b1;
    #1;
    check("abort_write_drop", 64'(o_write), 64'd0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", 64'(o_done), 64'd0);
    end
    check("abort_ready", 64'(o_ready), 64'd1);
    run_store(1'b0, 32'h7004, 3'b010, 64'h0BADF00D, 0);

    for (int n = 0; n < 300; n++) begin
      rf = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFF8 | (ra & 32'h7);
      if ($urandom_range(0, 1) == 0) ra = ra & ~(32'(1 << rf[1:0]) - 32'd1);
      run_store(1'($urandom_range(0, 1)), ra, rf, {$urandom, $urandom}, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end
endmodule
